mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port data-memory BRAM (registered read, 1-cycle latency) between two requesters.
//  Requester 0 is the CPU MEM stage; requester 1 is the loader/debug port.
//  Round-robin arbitration with one access in flight; drives the BRAM port and returns read data or a write ack.
//  Sits between the requesters and the Memory BRAM instance.
// PARAMETERS
//  ADDR_W  10  BRAM word-address width (1024 words)
//  DATA_W  32  data width
// PORTS
//  clk          in   1       single clock, rising edge
//  rst          in   1       asynchronous, active-low reset (0 = reset)
//  rq_valid_N   in   1       request N (N=0,1) valid; held with fields stable until rq_ready_N
//  rq_write_N   in   1       1 = write, 0 = read
//  rq_addr_N    in   32      word address
//  rq_wdata_N   in   DATA_W  write data
//  rq_ready_N   out  1       request N accepted this cycle (combinational)
//  rs_valid_N   out  1       1-cycle pulse: response for N (read data or write ack)
//  rs_rdata_N   out  DATA_W  read data, valid with rs_valid_N on reads; 0 otherwise
//  rs_err_N     out  1       bounds error, valid with rs_valid_N
//  mem_en       out  1       BRAM enable
//  mem_we       out  1       BRAM write enable
//  mem_addr     out  ADDR_W  BRAM address
//  mem_din      out  DATA_W  BRAM write data
//  mem_dout     in   DATA_W  BRAM read data (valid the cycle after the enable cycle)
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0 (port 0 favoured), all outputs 0.
//  FSM states: IDLE, ACCESS, RESP.
//  Accept window: IDLE or RESP; at most one accept per cycle.
//   - Winner: the only valid port; if both valid, the port != last winner (after reset, port 0).
//   - rq_ready_winner=1 combinationally. The command (port id, write, addr[ADDR_W-1:0], wdata) is registered.
//   - rr_ptr <= winner. Next state ACCESS.
//   - The loser's rq_ready stays 0; it must keep rq_valid asserted.
//  ACCESS (1 cycle): mem_en=1, mem_we=cmd_write, mem_addr/mem_din from the command register. -> RESP.
//  RESP (1 cycle): rs_valid_<cmd port>=1.
//   - Read: rs_rdata=mem_dout. Write: rs_rdata=0.
//   - A new accept in RESP goes directly to ACCESS; otherwise -> IDLE.
//  Timing: accept at cycle T, mem_en at T+1, rs_valid at T+2.
//  Throughput: 1 access per 2 cycles under continuous requests, strictly alternating when both ports are busy.
//  mem_en/mem_we are 0 in every state except ACCESS. The write hits the BRAM at the edge ending ACCESS.
//  Address: only rq_addr[ADDR_W-1:0] drives the BRAM. Upper bits are handled per CONFIGURATION.
//  Simultaneous rs_valid on both ports never occurs.
//  Reset mid-operation (any state): an in-flight access is dropped. No rs_valid is issued and mem_en is deasserted immediately. rr_ptr returns to 0.
// CONFIGURATION
//  MEM_ARB_BOUNDS_CHK_EN defined:
//   - A request with rq_addr[31:ADDR_W] != 0 is accepted normally.
//   - ACCESS keeps mem_en=0 and mem_we=0; no BRAM write occurs.
//   - RESP gives rs_valid=1, rs_err=1, rs_rdata=0. Latency is unchanged.
//  Not defined: upper address bits are ignored (address wraps modulo 2^ADDR_W); rs_err_N is tied to 0.
// TESTING
//  T1 reset: rst=0 mid-ACCESS -> mem_en=0 at once, no rs_valid; after release both rq_valid -> port 0 gets ready first.
//  T2 read: port0 write addr 5 data 0xDEADBEEF, then read addr 5 -> rs_valid_0 2 cycles after accept, rs_rdata_0=0xDEADBEEF.
//  T3 contention: both ports read continuously -> grants strictly alternate 0,1,0,1; one accept every 2 cycles; never both rs_valid.
//  T4 hold: port1 valid while port0 is in flight -> rq_ready_1 only in port0's RESP cycle; port1 fields unchanged until then.
//  T5 bounds (macro on): port1 write addr 0x400 data 0x1 -> mem_we stays 0, rs_err_1=1; read addr 0 shows its old value.
//  T6 wrap (macro off): write addr 0x405 data 0xA5 -> read addr 5 returns 0xA5, rs_err=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port, registered-read BRAM between two requesters.
// Define MEM_ARB_BOUNDS_CHK_EN to reject (with rs_err) requests whose upper address bits are set.
module mem_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rq_valid_0,
  input  logic              rq_write_0,
  input  logic [31:0]       rq_addr_0,
  input  logic [DATA_W-1:0] rq_wdata_0,
  output logic              rq_ready_0,
  output logic              rs_valid_0,
  output logic [DATA_W-1:0] rs_rdata_0,
  output logic              rs_err_0,
  input  logic              rq_valid_1,
  input  logic              rq_write_1,
  input  logic [31:0]       rq_addr_1,
  input  logic [DATA_W-1:0] rq_wdata_1,
  output logic              rq_ready_1,
  output logic              rs_valid_1,
  output logic [DATA_W-1:0] rs_rdata_1,
  output logic              rs_err_1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [1:0]        dbg_state
);

  // Handshake: a request is transferred in the cycle where rq_valid_N && rq_ready_N;
  // the requester holds valid and all fields stable until then. Responses are 1-cycle
  // rs_valid_N pulses with no back-pressure.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_rr_ptr;
  logic                r_rr_seen;
  logic                r_cmd_port;
  logic                r_cmd_write;
  logic                r_cmd_err;
  logic                r_mem_en;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_din;
  logic                r_rs_valid_0;
  logic                r_rs_valid_1;

  logic                w_window;
  logic                w_winner;
  logic                w_accept;
  logic                w_sel_write;
  logic                w_sel_err;
  logic                w_hi_0;
  logic                w_hi_1;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_unused_addr;

  // Accepts are blocked while reset is asserted so nothing is granted into a dropped cycle.
  assign w_window = rst && ((r_state == IDLE) || (r_state == RESP));

  // With no grant since reset, port 0 wins a tie; afterwards the last winner yields.
  assign w_winner = (rq_valid_0 && rq_valid_1) ? (r_rr_seen && !r_rr_ptr) : rq_valid_1;
  assign w_accept = w_window && (rq_valid_0 || rq_valid_1);

  assign rq_ready_0 = w_accept && !w_winner;
  assign rq_ready_1 = w_accept && w_winner;

  assign w_sel_write = w_winner ? rq_write_1 : rq_write_0;
  assign w_sel_addr  = w_winner ? rq_addr_1[ADDR_W-1:0] : rq_addr_0[ADDR_W-1:0];
  assign w_sel_wdata = w_winner ? rq_wdata_1 : rq_wdata_0;

`ifdef MEM_ARB_BOUNDS_CHK_EN
  assign w_hi_0 = |rq_addr_0[31:ADDR_W];
  assign w_hi_1 = |rq_addr_1[31:ADDR_W];
`else
  assign w_hi_0 = 1'b0;
  assign w_hi_1 = 1'b0;
`endif
  assign w_sel_err     = w_winner ? w_hi_1 : w_hi_0;
  assign w_unused_addr = ^{rq_addr_0[31:ADDR_W], rq_addr_1[31:ADDR_W]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_rr_ptr     <= 1'b0;
      r_rr_seen    <= 1'b0;
      r_cmd_port   <= 1'b0;
      r_cmd_write  <= 1'b0;
      r_cmd_err    <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_din    <= '0;
      r_rs_valid_0 <= 1'b0;
      r_rs_valid_1 <= 1'b0;
    end else begin
      case (r_state)
        IDLE, RESP: begin
          r_rs_valid_0 <= 1'b0;
          r_rs_valid_1 <= 1'b0;
          if (w_accept) begin
            r_cmd_port  <= w_winner;
            r_cmd_write <= w_sel_write;
            r_cmd_err   <= w_sel_err;
            r_rr_ptr    <= w_winner;
            r_rr_seen   <= 1'b1;
            // BRAM controls are registered here so they appear exactly in ACCESS.
            r_mem_en    <= !w_sel_err;
            r_mem_we    <= w_sel_write && !w_sel_err;
            r_mem_addr  <= w_sel_addr;
            r_mem_din   <= w_sel_wdata;
            r_state     <= ACCESS;
          end else begin
            r_state     <= IDLE;
          end
        end
        ACCESS: begin
          r_mem_en     <= 1'b0;
          r_mem_we     <= 1'b0;
          r_mem_addr   <= '0;
          r_mem_din    <= '0;
          r_rs_valid_0 <= !r_cmd_port;
          r_rs_valid_1 <= r_cmd_port;
          r_state      <= RESP;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // mem_dout is valid in RESP, the cycle after the enable cycle.
  assign rs_valid_0 = r_rs_valid_0;
  assign rs_valid_1 = r_rs_valid_1;
  assign rs_rdata_0 = (r_rs_valid_0 && !r_cmd_write && !r_cmd_err) ? mem_dout : '0;
  assign rs_rdata_1 = (r_rs_valid_1 && !r_cmd_write && !r_cmd_err) ? mem_dout : '0;
  assign rs_err_0   = r_rs_valid_0 && r_cmd_err;
  assign rs_err_1   = r_rs_valid_1 && r_cmd_err;

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_din   = r_mem_din;
  assign dbg_state = r_state;

endmodule
